// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : io_pkg
//  Purpose  : Shared I/O definitions for the output-pixel streaming path:
//             stream FSM state encoding, output-segment placement and the
//             start-register address decoded by topMemory.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package io_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } stream_state_t;

    localparam int OUT_BASE_ADDR = 24;
    localparam int OUT_DEPTH     = 10000;
    localparam int START_IO_ADDR = 180302;

    // Counter width for a count of n items; never narrower than one bit so
    // degenerate single-entry configurations still elaborate.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/word_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : word_serializer
//  Purpose  : Loads one PIXEL-bit word and presents it MSB byte first; each
//             shift moves the next byte up. A byte counter flags the last
//             byte of the word.
//  Ports    : clk, rst_n      clock, async active-low reset
//             clear           drop any held word (abort / end of transfer)
//             load, load_data capture a new word, byte counter to zero
//             shift           current byte consumed, advance to next byte
//             byte_out        byte currently at the top of the word
//             last_byte       byte_out is the final byte of the word
//  Revision : 1.0  initial release
// ============================================================================
module word_serializer
    import io_pkg::*;
#(
    parameter int PIXEL = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [PIXEL-1:0] load_data,
    input  logic             shift,
    output logic [7:0]       byte_out,
    output logic             last_byte
);

    localparam int c_BYTES = PIXEL / 8;
    localparam int c_CNT_W = cnt_width(c_BYTES);

    localparam logic [c_CNT_W-1:0] c_LAST_BYTE = c_CNT_W'(c_BYTES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE       = c_CNT_W'(1);

    logic [PIXEL-1:0]   r_shift;
    logic [c_CNT_W-1:0] r_byte_cnt;

    // clear beats load so an abort landing on the capture cycle leaves
    // nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (clear) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (load) begin
            r_shift    <= load_data;
            r_byte_cnt <= '0;
        end else if (shift) begin
            r_shift    <= r_shift << 8;
            r_byte_cnt <= r_byte_cnt + c_ONE;
        end
    end

    assign byte_out  = r_shift[PIXEL-1 -: 8];
    assign last_byte = (r_byte_cnt == c_LAST_BYTE);

endmodule
`default_nettype wire

// File: rtl/out_pixel_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : out_pixel_streamer
//  Purpose  : Drains the output-pixel segment BASE_ADDR..BASE_ADDR+DEPTH-1
//             over the dOutMem read port and serialises every word MSB byte
//             first onto a valid/ready byte stream for the host transmitter.
//  Ports    : clk, rst_n   clock, async active-low reset
//             start        one-cycle request to stream the whole segment
//             abort        stop immediately and return to idle
//             mem_addr     dOutMem read address (BASE_ADDR + word index)
//             mem_re       dOutMem read strobe, one cycle per word
//             mem_rd       dOutMem read data, valid the cycle after mem_re
//             m_data       stream byte
//             m_valid      m_data valid
//             m_ready      sink accepts the byte at a rising edge
//             busy         transfer in progress
//             done         one-cycle pulse after the last byte is accepted
//  Revision : 1.0  initial release
// ============================================================================
module out_pixel_streamer
    import io_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter int PIXEL     = 24,
    parameter int BASE_ADDR = OUT_BASE_ADDR,
    parameter int DEPTH     = OUT_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_re,
    input  logic [PIXEL-1:0] mem_rd,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             done
);

    localparam int c_CNT_W = cnt_width(DEPTH);

    localparam logic [c_CNT_W-1:0] c_LAST_WORD = c_CNT_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE       = c_CNT_W'(1);
    localparam logic [WIDTH-1:0]   c_BASE      = WIDTH'(BASE_ADDR);

    stream_state_t      r_state;
    logic [c_CNT_W-1:0] r_word_cnt;

    logic       w_handshake;
    logic       w_last_byte;
    logic [7:0] w_byte;

    // A byte is consumed only when not aborting; abort takes precedence over
    // a coincident handshake so no state advances on that edge.
    assign w_handshake = (r_state == SEND) && m_ready && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_word_cnt <= '0;
        end else if (abort) begin
            r_state    <= IDLE;
            r_word_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= READ;
                    end
                end
                READ: r_state <= WAIT;
                WAIT: r_state <= SEND;
                SEND: begin
                    if (w_handshake && w_last_byte) begin
                        if (r_word_cnt == c_LAST_WORD) begin
                            r_state <= DONE;
                        end else begin
                            r_word_cnt <= r_word_cnt + c_ONE;
                            r_state    <= READ;
                        end
                    end
                end
                DONE: begin
                    r_word_cnt <= '0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state    <= IDLE;
                    r_word_cnt <= '0;
                end
            endcase
        end
    end

    // The word counter stays on the last word through DONE, so the address
    // never steps past the end of the segment.
    word_serializer #(
        .PIXEL (PIXEL)
    ) u_word_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (abort || (r_state == DONE)),
        .load      (r_state == WAIT),
        .load_data (mem_rd),
        .shift     (w_handshake),
        .byte_out  (w_byte),
        .last_byte (w_last_byte)
    );

    // All stream outputs decode from registered state only, so m_valid has
    // no combinational path from m_ready and async reset clears them at once.
    assign mem_addr = c_BASE + WIDTH'(r_word_cnt);
    assign mem_re   = (r_state == READ);
    assign m_valid  = (r_state == SEND);
    assign m_data   = (r_state == SEND) ? w_byte : 8'h00;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_out_pixel_streamer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_out_pixel_streamer
//  Purpose  : Self-checking bench for out_pixel_streamer. A small instance
//             (DEPTH=4) covers cycle-exact sequencing, backpressure, ignored
//             start, abort and async reset; a default instance (DEPTH=10000)
//             is drained end to end.
//  Revision : 1.0  initial release
// ============================================================================
module tb_out_pixel_streamer;

    localparam int c_BASE    = 24;
    localparam int c_DEPTH_A = 4;
    localparam int c_DEPTH_B = 10000;
    localparam int c_BYTES   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: DEPTH=4 ----------------
    logic        start_a   = 1'b0;
    logic        abort_a   = 1'b0;
    logic        m_ready_a = 1'b0;
    logic [23:0] mem_addr_a;
    logic        mem_re_a;
    logic [23:0] mem_rd_a  = '0;
    logic [7:0]  m_data_a;
    logic        m_valid_a, busy_a, done_a;

    out_pixel_streamer #(
        .WIDTH(24), .PIXEL(24), .BASE_ADDR(c_BASE), .DEPTH(c_DEPTH_A)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .mem_addr(mem_addr_a), .mem_re(mem_re_a), .mem_rd(mem_rd_a),
        .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
        .busy(busy_a), .done(done_a)
    );

    // ---------------- DUT B: default DEPTH ----------------
    logic        start_b   = 1'b0;
    logic        abort_b   = 1'b0;
    logic        m_ready_b = 1'b1;
    logic [23:0] mem_addr_b;
    logic        mem_re_b;
    logic [23:0] mem_rd_b  = '0;
    logic [7:0]  m_data_b;
    logic        m_valid_b, busy_b, done_b;

    out_pixel_streamer dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .mem_addr(mem_addr_b), .mem_re(mem_re_b), .mem_rd(mem_rd_b),
        .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
        .busy(busy_b), .done(done_b)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] rx_q[$];
    int  busy_cyc = 0, done_cnt = 0, stalls = 0, oob_a = 0;
    bit  chk_hold = 1'b0;
    logic [7:0] held_data = '0;

    int  nb_b = 0, bad_b = 0, done_b_cnt = 0, oob_b = 0;
    logic [23:0] max_addr_b = '0;

    // Segment contents: word i holds i * 0x010203 (truncated to 24 bits).
    function automatic logic [23:0] pixel_word(input int idx);
        int p;
        p = idx * 66051;
        return p[23:0];
    endfunction

    function automatic logic [7:0] stream_byte(input int k);
        logic [23:0] w;
        w = pixel_word(k / c_BYTES);
        case (k % c_BYTES)
            0:       return w[23:16];
            1:       return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    // Memory models: registered 1-cycle read, garbage when not reading.
    always @(posedge clk) begin
        if (mem_re_a) begin
            if (int'(mem_addr_a) < c_BASE || int'(mem_addr_a) >= c_BASE + c_DEPTH_A) oob_a++;
            mem_rd_a <= pixel_word(int'(mem_addr_a) - c_BASE);
        end else begin
            mem_rd_a <= 24'($urandom);
        end
        if (mem_re_b) begin
            if (int'(mem_addr_b) < c_BASE || int'(mem_addr_b) >= c_BASE + c_DEPTH_B) oob_b++;
            mem_rd_b <= pixel_word(int'(mem_addr_b) - c_BASE);
        end else begin
            mem_rd_b <= 24'($urandom);
        end
    end

    // Monitor A: collects accepted bytes and checks stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy_a) busy_cyc++;
            if (done_a) done_cnt++;
            if (chk_hold) begin
                n_cmp++;
                if (!(m_valid_a === 1'b1 && m_data_a === held_data)) begin
                    n_fail++;
                    $display("FAIL stall_hold: m_valid=%0b m_data=%02h, required m_valid=1 m_data=%02h",
                             m_valid_a, m_data_a, held_data);
                end
            end
            chk_hold  = m_valid_a && !m_ready_a && !abort_a;
            held_data = m_data_a;
            if (m_valid_a && !m_ready_a) stalls++;
            if (m_valid_a && m_ready_a && !abort_a) rx_q.push_back(m_data_a);
        end else begin
            chk_hold = 1'b0;
        end
    end

    // Monitor B: compares every byte against the reference on the fly.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid_b && m_ready_b) begin
                if (m_data_b !== stream_byte(nb_b)) bad_b++;
                nb_b++;
            end
            if (mem_re_b && mem_addr_b > max_addr_b) max_addr_b = mem_addr_b;
            if (done_b) done_b_cnt++;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack_a();
        return 64'({mem_re_a, m_valid_a, busy_a, done_a, m_data_a, mem_addr_a});
    endfunction

    function automatic logic [63:0] pack_exp(input logic re, input logic v, input logic b,
                                             input logic d, input logic [7:0] data,
                                             input logic [23:0] addr);
        return 64'({re, v, b, d, data, addr});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        rx_q.delete();
        busy_cyc = 0;
        done_cnt = 0;
        stalls   = 0;
    endtask

    task automatic pulse_start();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic run_until_done(input bit rnd, input int bound, input string name);
        int n;
        n = 0;
        while (done_cnt == 0 && n < bound) begin
            m_ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        check({name, " done_seen"}, 64'(done_cnt > 0), 64'd1);
        m_ready_a = 1'b1;
        repeat (3) tick();
    endtask

    task automatic wait_rx(input int k, input int bound, input string name);
        int n;
        n = 0;
        m_ready_a = 1'b1;
        while (rx_q.size() < k && n < bound) begin
            tick();
            n++;
        end
        check({name, " reached_byte"}, 64'(rx_q.size()), 64'(k));
    endtask

    task automatic check_stream(input string name);
        logic [7:0] ref_q[$];
        int first_bad;
        for (int k = 0; k < c_DEPTH_A * c_BYTES; k++) ref_q.push_back(stream_byte(k));
        check({name, " byte_count"}, 64'(rx_q.size()), 64'(ref_q.size()));
        first_bad = -1;
        for (int k = 0; k < rx_q.size() && k < ref_q.size(); k++) begin
            if (first_bad < 0 && rx_q[k] !== ref_q[k]) first_bad = k;
        end
        check({name, " first_bad_byte_index"}, 64'(first_bad), 64'(-1));
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; m_ready_a = 1'b0;
        start_b = 1'b0;
        repeat (2) @(negedge clk);
        check("reset outputs", pack_a(), pack_exp(0, 0, 0, 0, 8'h00, 24'd24));
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- cycle table ----------------
    typedef struct {
        logic        start;
        logic        ready;
        logic        re;
        logic        valid;
        logic        busy;
        logic        done;
        logic [7:0]  data;
        logic [23:0] addr;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int bound;
        // Inputs drive this cycle; outputs are what must be visible in it.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'd24}; // idle, start
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 24'd24}; // READ w0
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 24'd24}; // WAIT
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 24'd24}; // w0 b0
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 24'd24}; // w0 b1
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 24'd24}; // w0 b2
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 24'd25}; // READ w1
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 24'd25}; // WAIT
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 24'd25}; // stall
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 24'd25}; // start ignored
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h02, 24'd25};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 24'd25};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 24'd26}; // READ w2

        apply_reset();

        // ---- 1) cycle-exact start of a transfer, then drain ----
        clear_stats();
        for (int i = 0; i < 13; i++) begin
            start_a   = tbl[i].start;
            m_ready_a = tbl[i].ready;
            @(negedge clk);
            check($sformatf("table row %0d", i), pack_a(),
                  pack_exp(tbl[i].re, tbl[i].valid, tbl[i].busy, tbl[i].done,
                           tbl[i].data, tbl[i].addr));
            tick();
        end
        start_a = 1'b0;
        run_until_done(1'b0, 200, "t1");
        check_stream("t1");
        check("t1 done pulses", 64'(done_cnt), 64'd1);
        check("t1 busy cycles", 64'(busy_cyc), 64'(c_DEPTH_A * (c_BYTES + 2) + 1 + stalls));
        check("t1 idle outputs", pack_a(), pack_exp(0, 0, 0, 0, 8'h00, 24'd24));

        // ---- 2) random backpressure ----
        clear_stats();
        pulse_start();
        run_until_done(1'b1, 600, "t2");
        check_stream("t2");
        check("t2 done pulses", 64'(done_cnt), 64'd1);
        check("t2 busy cycles", 64'(busy_cyc), 64'(c_DEPTH_A * (c_BYTES + 2) + 1 + stalls));

        // ---- 3) start while busy is ignored ----
        clear_stats();
        pulse_start();
        wait_rx(4, 100, "t3");
        pulse_start();
        run_until_done(1'b0, 200, "t3");
        repeat (10) tick();
        check_stream("t3");
        check("t3 done pulses", 64'(done_cnt), 64'd1);
        check("t3 busy after", 64'(busy_a), 64'd0);

        // ---- 4) abort with byte 2 of word 1 pending ----
        clear_stats();
        pulse_start();
        wait_rx(5, 100, "t4");
        abort_a   = 1'b1;
        m_ready_a = 1'b0;
        @(negedge clk);
        check("t4 pending byte", 64'({m_valid_a, m_data_a}), 64'({1'b1, 8'h03}));
        tick();
        abort_a   = 1'b0;
        m_ready_a = 1'b1;
        @(negedge clk);
        check("t4 after abort", pack_a(), pack_exp(0, 0, 0, 0, 8'h00, 24'd24));
        repeat (20) tick();
        check("t4 no done", 64'(done_cnt), 64'd0);
        check("t4 no extra bytes", 64'(rx_q.size()), 64'd5);
        clear_stats();
        pulse_start();
        run_until_done(1'b0, 200, "t4 restart");
        check_stream("t4 restart");

        // ---- 5) async reset mid-SEND ----
        clear_stats();
        pulse_start();
        wait_rx(2, 100, "t5");
        #2;
        check("t5 mid send", 64'({m_valid_a, m_data_a}), 64'({1'b1, 8'h00}));
        rst_n = 1'b0;
        #1;
        check("t5 async reset", pack_a(), pack_exp(0, 0, 0, 0, 8'h00, 24'd24));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_stats();
        pulse_start();
        run_until_done(1'b0, 200, "t5 restart");
        check_stream("t5 restart");
        check("t5 done pulses", 64'(done_cnt), 64'd1);
        check("A out-of-segment reads", 64'(oob_a), 64'd0);

        // ---- 6) full default-depth drain ----
        nb_b = 0; bad_b = 0; done_b_cnt = 0; max_addr_b = '0;
        m_ready_b = 1'b1;
        start_b   = 1'b1;
        tick();
        start_b   = 1'b0;
        bound = 0;
        while (done_b_cnt == 0 && bound < 60000) begin
            tick();
            bound++;
        end
        repeat (3) tick();
        check("t6 done pulses", 64'(done_b_cnt), 64'd1);
        check("t6 byte count", 64'(nb_b), 64'(c_DEPTH_B * c_BYTES));
        check("t6 wrong bytes", 64'(bad_b), 64'd0);
        check("t6 last read addr", 64'(max_addr_b), 64'd10023);
        check("t6 out-of-segment reads", 64'(oob_b), 64'd0);
        check("t6 idle addr", 64'({busy_b, mem_addr_b}), 64'({1'b0, 24'd24}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
